// File: rtl/link_monitor_mc_pkg.sv
// Shared state encodings and helpers for the multi-lane link monitor.
// Optional link-fail statistics are enabled with the LINK_MONITOR_STATS_EN macro.
package link_monitor_mc_pkg;

  typedef enum logic [1:0] {
    LM_DOWN      = 2'd0,
    LM_STABILIZE = 2'd1,
    LM_READY     = 2'd2,
    LM_UP        = 2'd3
  } lm_state_t;

  function automatic int lm_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/link_monitor_mc_lane.sv
// One lane of the link monitor: FSM, stabilise timer, loss filter, optional fail counter.
// The fail counter exists only when LINK_MONITOR_STATS_EN is defined.
module link_monitor_lane
  import link_monitor_mc_pkg::*;
#(
  parameter int TIMER_WIDTH      = 17,
  parameter int STABILIZE_CYCLES = 41250,
  parameter int TEST_CYCLES      = 16,
  parameter int LOSS_FILTER      = 0,
  parameter int STAT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_status,
  input  logic                  locked,
  input  logic                  loopback,
  input  logic                  test_mode,
  input  logic                  clear_stats,
  output logic [1:0]            state,
  output logic [STAT_WIDTH-1:0] fail_count
);

  localparam int LW = (LOSS_FILTER < 1) ? 1 : lm_clog2(LOSS_FILTER + 1);

  lm_state_t              state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d, load_val;
  logic [LW-1:0]          loss_q, loss_d;
  logic                   lb_q;
  logic                   lb_rise, lb_fall;
  lm_state_t              lock_next;

  assign load_val  = test_mode ? TIMER_WIDTH'(TEST_CYCLES - 1) : TIMER_WIDTH'(STABILIZE_CYCLES - 1);
  assign lb_rise   = loopback & ~lb_q;
  assign lb_fall   = ~loopback & lb_q;
  assign lock_next = locked ? LM_UP : LM_READY;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    loss_d  = '0;
    if (lb_fall) begin
      state_d = LM_DOWN;
    end else if (loopback) begin
      // Loopback bypasses the timer and loss filter; only lock matters.
      state_d = lb_rise ? LM_READY : lock_next;
    end else begin
      case (state_q)
        LM_DOWN: begin
          if (signal_status) state_d = LM_STABILIZE;
        end
        LM_STABILIZE: begin
          if (!signal_status)      state_d = LM_DOWN;
          else if (timer_q == '0)  state_d = LM_READY;
          else                     timer_d = timer_q - TIMER_WIDTH'(1);
        end
        default: begin
          if (!signal_status) begin
            if (loss_q == LW'(LOSS_FILTER)) begin
              state_d = LM_DOWN;
            end else begin
              loss_d  = loss_q + LW'(1);
              state_d = lock_next;
            end
          end else begin
            state_d = lock_next;
          end
        end
      endcase
    end
    // test_mode is only looked at here, so a running count is never disturbed.
    if (state_q == LM_DOWN || state_d == LM_DOWN) timer_d = load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LM_DOWN;
      timer_q <= load_val;
      loss_q  <= '0;
      lb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      loss_q  <= loss_d;
      lb_q    <= loopback;
    end
  end

`ifdef LINK_MONITOR_STATS_EN
  logic [STAT_WIDTH-1:0] cnt_q;
  logic                  up_exit;

  assign up_exit    = (state_q == LM_UP) && (state_d != LM_UP);
  assign fail_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_stats) begin
      cnt_q <= STAT_WIDTH'(up_exit);
    end else if (up_exit && !(&cnt_q)) begin
      cnt_q <= cnt_q + STAT_WIDTH'(1);
    end
  end
`else
  logic unused_clear_stats;
  assign unused_clear_stats = clear_stats;
  assign fail_count         = '0;
`endif

endmodule

// File: rtl/link_monitor_mc.sv
// Multi-lane PMA link monitor: one independent link_monitor_lane per lane.
// Define LINK_MONITOR_STATS_EN to enable per-lane link-fail counters.
module link_monitor_mc
  import link_monitor_mc_pkg::*;
#(
  parameter int LANES            = 1,
  parameter int TIMER_WIDTH      = 17,
  parameter int STABILIZE_CYCLES = 41250,
  parameter int TEST_CYCLES      = 16,
  parameter int LOSS_FILTER      = 0,
  parameter int STAT_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES-1:0]            signal_status,
  input  logic [LANES-1:0]            locked,
  input  logic [LANES-1:0]            loopback,
  input  logic                        test_mode,
  input  logic                        clear_stats,
  output logic [LANES-1:0]            link_status,
  output logic [LANES-1:0]            stabilizing,
  output logic [LANES*STAT_WIDTH-1:0] link_fail_count
);

  if ((2 ** TIMER_WIDTH) < STABILIZE_CYCLES) begin : g_timer_too_narrow
    $error("TIMER_WIDTH too small for STABILIZE_CYCLES");
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [1:0] lane_state;

    link_monitor_lane #(
      .TIMER_WIDTH      (TIMER_WIDTH),
      .STABILIZE_CYCLES (STABILIZE_CYCLES),
      .TEST_CYCLES      (TEST_CYCLES),
      .LOSS_FILTER      (LOSS_FILTER),
      .STAT_WIDTH       (STAT_WIDTH)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .signal_status (signal_status[i]),
      .locked        (locked[i]),
      .loopback      (loopback[i]),
      .test_mode     (test_mode),
      .clear_stats   (clear_stats),
      .state         (lane_state),
      .fail_count    (link_fail_count[i*STAT_WIDTH +: STAT_WIDTH])
    );

    // Pure decode of registered state: no input-to-output path.
    assign link_status[i] = (lane_state == LM_UP);
    assign stabilizing[i] = (lane_state == LM_STABILIZE);
  end

endmodule
